// File: rtl/mem_interface_multi_pkg.sv
// ----------------------------------------------------------------------------
// mem_interface_multi_pkg
// Shared constants for the multicycle memory interface: FSM state encodings,
// RV32I load/store funct3 codes, the NOP instruction, and a helper that maps
// funct3 onto an access size.
// ----------------------------------------------------------------------------
package mem_interface_multi_pkg;

    typedef enum logic [1:0] {
        MEMIF_IDLE = 2'd0,
        MEMIF_RD   = 2'd1,
        MEMIF_WR   = 2'd2
    } memif_state_e;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Low funct3 bits give the size; the unused code 11 is treated as a word.
    function automatic logic [1:0] accessSize(input logic [2:0] funct3);
        logic [1:0] size;
        case (funct3[1:0])
            2'b00:   size = SIZE_BYTE;
            2'b01:   size = SIZE_HALF;
            default: size = SIZE_WORD;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_interface_multi_load_store_align.sv
// ----------------------------------------------------------------------------
// mem_interface_multi_load_store_align
// Purely combinational lane logic for the memory interface.
//   reqFunct3_i / reqAddrLo_i : size and low address of the access being
//                               requested now (store lanes, misalignment)
//   storeData_i               : store data from the B register
//   ldFunct3_i / ldAddrLo_i   : size and low address latched for the read
//   loadWord_i                : raw word returned by the bus
//   be_o / wData_o            : byte enables and lane-replicated store data
//   loadData_o                : sign/zero-extended load result
//   misaligned_o              : requested access crosses its natural boundary
// ----------------------------------------------------------------------------
module mem_interface_multi_load_store_align
    import mem_interface_multi_pkg::*;
(
    input  logic [2:0]  reqFunct3_i,
    input  logic [1:0]  reqAddrLo_i,
    input  logic [31:0] storeData_i,
    input  logic [2:0]  ldFunct3_i,
    input  logic [1:0]  ldAddrLo_i,
    input  logic [31:0] loadWord_i,
    output logic [3:0]  be_o,
    output logic [31:0] wData_o,
    output logic [31:0] loadData_o,
    output logic        misaligned_o
);

    logic [1:0]  reqSize;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    // Store side: data is replicated across lanes so the byte enables alone
    // pick the destination bytes.
    always_comb begin
        reqSize      = accessSize(reqFunct3_i);
        misaligned_o = 1'b0;
        be_o         = 4'b1111;
        wData_o      = storeData_i;
        case (reqSize)
            SIZE_BYTE: begin
                be_o    = 4'b0001 << reqAddrLo_i;
                wData_o = {4{storeData_i[7:0]}};
            end
            SIZE_HALF: begin
                misaligned_o = reqAddrLo_i[0];
                be_o         = 4'b0011 << reqAddrLo_i;
                wData_o      = {2{storeData_i[15:0]}};
            end
            default: begin
                misaligned_o = (reqAddrLo_i != 2'b00);
            end
        endcase
    end

    // Load side: pick the addressed byte/half of the returned word and extend.
    always_comb begin
        case (ldAddrLo_i)
            2'd0:    ldByte = loadWord_i[7:0];
            2'd1:    ldByte = loadWord_i[15:8];
            2'd2:    ldByte = loadWord_i[23:16];
            default: ldByte = loadWord_i[31:24];
        endcase
        ldHalf = ldAddrLo_i[1] ? loadWord_i[31:16] : loadWord_i[15:0];
        case (ldFunct3_i)
            FUNCT3_LB:  loadData_o = {{24{ldByte[7]}}, ldByte};
            FUNCT3_LBU: loadData_o = {24'd0, ldByte};
            FUNCT3_LH:  loadData_o = {{16{ldHalf[15]}}, ldHalf};
            FUNCT3_LHU: loadData_o = {16'd0, ldHalf};
            default:    loadData_o = loadWord_i;
        endcase
    end

endmodule

// File: rtl/mem_interface_multi.sv
// ----------------------------------------------------------------------------
// mem_interface_multi
// Turns the multicycle control unit's two-cycle memory windows into single
// requests on a one-cycle-latency synchronous bus, capturing fetches into IR
// and loads (extended) into MDR.
//   iCLK, iRST            : clock, asynchronous active-high reset
//   iMemRead/iMemWrite    : memory strobes from control
//   iIouD                 : 0 = fetch from iPC, 1 = data access at iALUOut
//   iEscreveIR            : IR write enable
//   iWriteData, iFunct3   : store data and access size/sign
//   iBusRData             : bus read data (valid the cycle after a request)
//   oBus*                 : request, write enable, word address, data, BE
//   oIR, oMDR             : instruction and memory data registers
//   oMisaligned, oBusy    : misaligned-access pulse, window in progress
// ----------------------------------------------------------------------------
module mem_interface_multi
    import mem_interface_multi_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
)(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic              iIouD,
    input  logic              iEscreveIR,
    input  logic [ADDR_W-1:0] iPC,
    input  logic [ADDR_W-1:0] iALUOut,
    input  logic [31:0]       iWriteData,
    input  logic [2:0]        iFunct3,
    input  logic [31:0]       iBusRData,
    output logic              oBusReq,
    output logic              oBusWE,
    output logic [ADDR_W-1:0] oBusAddr,
    output logic [31:0]       oBusWData,
    output logic [3:0]        oBusBE,
    output logic [31:0]       oIR,
    output logic [31:0]       oMDR,
    output logic              oMisaligned,
    output logic              oBusy
);

    memif_state_e state_q;
    logic [31:0]  ir_q;
    logic [31:0]  mdr_q;
    logic [1:0]   addrLo_q;
    logic [2:0]   funct3_q;
    logic         iouD_q;
    logic         aligned_q;

    logic [ADDR_W-1:0] reqAddr;
    logic [2:0]        reqFunct3;
    logic              startAccess;
    logic              misaligned;
    logic [3:0]        be;
    logic [31:0]       loadData;

    // Fetches are always full words regardless of what IR[14:12] holds.
    assign reqAddr     = iIouD ? iALUOut : iPC;
    assign reqFunct3   = iIouD ? iFunct3 : FUNCT3_LW;
    assign startAccess = (state_q == MEMIF_IDLE) && (iMemRead || iMemWrite);

    mem_interface_multi_load_store_align uAlign (
        .reqFunct3_i  (reqFunct3),
        .reqAddrLo_i  (reqAddr[1:0]),
        .storeData_i  (iWriteData),
        .ldFunct3_i   (funct3_q),
        .ldAddrLo_i   (addrLo_q),
        .loadWord_i   (iBusRData),
        .be_o         (be),
        .wData_o      (oBusWData),
        .loadData_o   (loadData),
        .misaligned_o (misaligned)
    );

    // A misaligned access still opens the window but never reaches the bus.
    assign oBusReq     = startAccess && !misaligned;
    assign oBusWE      = oBusReq && iMemWrite;
    assign oBusBE      = oBusWE ? be : 4'b0000;
    assign oBusAddr    = {reqAddr[ADDR_W-1:2], 2'b00};
    assign oMisaligned = startAccess && misaligned;
    assign oBusy       = (state_q != MEMIF_IDLE);
    assign oIR         = ir_q;
    assign oMDR        = mdr_q;

    // Window FSM; address/size are frozen in IDLE so mid-window input
    // changes cannot corrupt the capture. Write wins over a same-cycle read.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= MEMIF_IDLE;
            ir_q      <= NOP_INSTR;
            mdr_q     <= 32'd0;
            addrLo_q  <= 2'd0;
            funct3_q  <= FUNCT3_LW;
            iouD_q    <= 1'b0;
            aligned_q <= 1'b0;
        end else begin
            case (state_q)
                MEMIF_IDLE: begin
                    if (startAccess) begin
                        addrLo_q  <= reqAddr[1:0];
                        funct3_q  <= reqFunct3;
                        iouD_q    <= iIouD;
                        aligned_q <= !misaligned;
                    end
                    if (iMemWrite) begin
                        state_q <= MEMIF_WR;
                    end else if (iMemRead) begin
                        state_q <= MEMIF_RD;
                    end
                end
                MEMIF_RD: begin
                    if (iMemRead && aligned_q) begin
                        if (iouD_q) begin
                            mdr_q <= loadData;
                        end else if (iEscreveIR) begin
                            ir_q <= iBusRData;
                        end
                    end
                    state_q <= MEMIF_IDLE;
                end
                MEMIF_WR: begin
                    state_q <= MEMIF_IDLE;
                end
                default: begin
                    state_q <= MEMIF_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_interface_multi.sv
// ----------------------------------------------------------------------------
// tb_mem_interface_multi
// Drives fetch, load, store, misaligned, aborted and reset-interrupted memory
// windows into mem_interface_multi. Expected IR/MDR contents are queued when
// each window is driven and compared once the window has finished.
// ----------------------------------------------------------------------------
module tb_mem_interface_multi;

    logic        clk;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic        iouD;
    logic        escreveIR;
    logic [31:0] pc;
    logic [31:0] aluOut;
    logic [31:0] writeData;
    logic [2:0]  funct3;
    logic [31:0] busRData;
    logic        busReq;
    logic        busWE;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [3:0]  busBE;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        misaligned;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    logic [31:0] modelIR  = 32'h0000_0013;
    logic [31:0] modelMDR = 32'd0;

    mem_interface_multi #(
        .ADDR_W    (32),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iMemRead    (memRead),
        .iMemWrite   (memWrite),
        .iIouD       (iouD),
        .iEscreveIR  (escreveIR),
        .iPC         (pc),
        .iALUOut     (aluOut),
        .iWriteData  (writeData),
        .iFunct3     (funct3),
        .iBusRData   (busRData),
        .oBusReq     (busReq),
        .oBusWE      (busWE),
        .oBusAddr    (busAddr),
        .oBusWData   (busWData),
        .oBusBE      (busBE),
        .oIR         (ir),
        .oMDR        (mdr),
        .oMisaligned (misaligned),
        .oBusy       (busy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the DUT disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Reference load extension written from the RV32I definition.
    function automatic logic [31:0] refLoad(input logic [2:0] f3,
                                            input logic [1:0] lo,
                                            input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * lo);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic refAligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return !lo[0];
            default: return lo == 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] refBE(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'(1 << lo);
            2'b01:   return 4'(3 << lo);
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] refWData(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'b01:   return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    task automatic pushState();
        sb.push_back('{tag: "IR",  val: modelIR});
        sb.push_back('{tag: "MDR", val: modelMDR});
    endtask

    task automatic drainScoreboard();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.tag == "IR") checkOutput(e.tag, ir, e.val);
            else               checkOutput(e.tag, mdr, e.val);
        end
    endtask

    // One read window: request cycle, data cycle, then result comparison.
    task automatic applyStimulus(input string name, input logic isData,
                                 input logic [31:0] addr, input logic escIR,
                                 input logic [2:0] f3, input logic [31:0] word,
                                 input logic abort);
        logic [2:0] effF3;
        logic       ok;
        effF3 = isData ? f3 : 3'b010;
        ok    = refAligned(effF3, addr[1:0]);
        @(negedge clk);
        memRead   = 1'b1;
        memWrite  = 1'b0;
        iouD      = isData;
        escreveIR = escIR;
        funct3    = f3;
        if (isData) begin
            aluOut = addr;
            pc     = 32'hFFFF_FFF0;
        end else begin
            pc     = addr;
            aluOut = 32'hFFFF_FFF0;
        end
        busRData = 32'hCAFE_0000;
        #1;
        checkOutput({name, ".req1"}, 32'(busReq), 32'(ok));
        checkOutput({name, ".mis"}, 32'(misaligned), 32'(!ok));
        if (ok) checkOutput({name, ".addr"}, busAddr, {addr[31:2], 2'b00});
        @(negedge clk);
        busRData = word;
        aluOut   = 32'h0000_0000;
        pc       = 32'h0000_0000;
        funct3   = 3'b111;
        if (abort) memRead = 1'b0;
        #1;
        checkOutput({name, ".req2"}, 32'(busReq), 32'd0);
        checkOutput({name, ".busy"}, 32'(busy), 32'd1);
        if (!abort && ok) begin
            if (isData)     modelMDR = refLoad(f3, addr[1:0], word);
            else if (escIR) modelIR  = word;
        end
        pushState();
        @(negedge clk);
        memRead   = 1'b0;
        escreveIR = 1'b0;
        busRData  = 32'hCAFE_1111;
        #1;
        checkOutput({name, ".idle"}, 32'(busy), 32'd0);
        drainScoreboard();
    endtask

    // One write window; alsoRead raises MemRead too, which must be ignored.
    task automatic applyWrite(input string name, input logic [31:0] addr,
                              input logic [2:0] f3, input logic [31:0] data,
                              input logic alsoRead);
        logic ok;
        ok = refAligned(f3, addr[1:0]);
        @(negedge clk);
        memWrite  = 1'b1;
        memRead   = alsoRead;
        iouD      = 1'b1;
        escreveIR = alsoRead;
        aluOut    = addr;
        funct3    = f3;
        writeData = data;
        #1;
        checkOutput({name, ".req"}, 32'(busReq), 32'(ok));
        checkOutput({name, ".we"}, 32'(busWE), 32'(ok));
        checkOutput({name, ".mis"}, 32'(misaligned), 32'(!ok));
        if (ok) begin
            checkOutput({name, ".be"}, 32'(busBE), 32'(refBE(f3, addr[1:0])));
            checkOutput({name, ".wdata"}, busWData, refWData(f3, data));
            checkOutput({name, ".addr"}, busAddr, {addr[31:2], 2'b00});
        end
        @(negedge clk);
        memWrite = 1'b0;
        busRData = 32'h1234_5678;
        #1;
        checkOutput({name, ".req2"}, 32'(busReq), 32'd0);
        checkOutput({name, ".busy"}, 32'(busy), 32'd1);
        pushState();
        @(negedge clk);
        memRead   = 1'b0;
        escreveIR = 1'b0;
        #1;
        checkOutput({name, ".idle"}, 32'(busy), 32'd0);
        drainScoreboard();
    endtask

    initial begin
        rst       = 1'b1;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        iouD      = 1'b0;
        escreveIR = 1'b0;
        pc        = 32'd0;
        aluOut    = 32'd0;
        writeData = 32'd0;
        funct3    = 3'b000;
        busRData  = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst.ir", ir, 32'h0000_0013);
        checkOutput("rst.mdr", mdr, 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.req", 32'(busReq), 32'd0);
        checkOutput("rst.mis", 32'(misaligned), 32'd0);
        checkOutput("rst.be", 32'(busBE), 32'd0);

        applyStimulus("fetch", 1'b0, 32'h0000_0010, 1'b1, 3'b000, 32'h0050_0093, 1'b0);
        applyStimulus("lb",    1'b1, 32'h0000_0203, 1'b0, 3'b000, 32'h80FF_1234, 1'b0);
        applyStimulus("lbu",   1'b1, 32'h0000_0203, 1'b0, 3'b100, 32'h80FF_1234, 1'b0);
        applyStimulus("lh",    1'b1, 32'h0000_0202, 1'b0, 3'b001, 32'h80FF_1234, 1'b0);
        applyStimulus("lhu",   1'b1, 32'h0000_0200, 1'b0, 3'b101, 32'h80FF_9234, 1'b0);
        applyStimulus("lbu1",  1'b1, 32'h0000_0201, 1'b0, 3'b100, 32'h80FF_9234, 1'b0);
        applyStimulus("lw",    1'b1, 32'h0000_0204, 1'b0, 3'b010, 32'hA5A5_0F0F, 1'b0);
        applyStimulus("lwmis", 1'b1, 32'h0000_0101, 1'b0, 3'b010, 32'h1111_2222, 1'b0);
        applyStimulus("lhmis", 1'b1, 32'h0000_0103, 1'b0, 3'b001, 32'h3333_4444, 1'b0);
        applyStimulus("abort", 1'b0, 32'h0000_0020, 1'b1, 3'b000, 32'hDEAD_BEEF, 1'b1);
        applyStimulus("noEsc", 1'b0, 32'h0000_0024, 1'b0, 3'b000, 32'hBAAD_F00D, 1'b0);
        applyStimulus("fetch2",1'b0, 32'h0000_0014, 1'b1, 3'b001, 32'h0010_0113, 1'b0);

        applyWrite("sh",    32'h0000_0102, 3'b001, 32'h0000_BEEF, 1'b0);
        applyWrite("sb",    32'h0000_0101, 3'b000, 32'h0000_00A5, 1'b0);
        applyWrite("sw",    32'h0000_0100, 3'b010, 32'h0123_4567, 1'b0);
        applyWrite("shmis", 32'h0000_0101, 3'b001, 32'h0000_BEEF, 1'b0);
        applyWrite("wrrd",  32'h0000_0108, 3'b010, 32'h7654_3210, 1'b1);

        // Reset pulsed during the data cycle of a fetch.
        @(negedge clk);
        memRead   = 1'b1;
        iouD      = 1'b0;
        escreveIR = 1'b1;
        pc        = 32'h0000_0030;
        @(negedge clk);
        busRData = 32'hDEAD_BEEF;
        #1;
        checkOutput("rstmid.busyPre", 32'(busy), 32'd1);
        #1;
        rst       = 1'b1;
        memRead   = 1'b0;
        escreveIR = 1'b0;
        #1;
        checkOutput("rstmid.busy", 32'(busy), 32'd0);
        checkOutput("rstmid.ir", ir, 32'h0000_0013);
        #1;
        rst = 1'b0;
        modelIR  = 32'h0000_0013;
        modelMDR = 32'd0;
        pushState();
        @(negedge clk);
        #1;
        drainScoreboard();

        applyStimulus("fetch3", 1'b0, 32'h0000_0040, 1'b1, 3'b000, 32'h0000_0537, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
